// File: rtl/seg_decoder_if.sv
// Bus between a multiplexed 7-segment display driver and the frame decoder.
interface seg_decoder_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        valid;
  logic        err;
  logic        busy;

  modport master (output seg, an, input value, valid, err, busy);
  modport slave  (input seg, an, output value, valid, err, busy);
endinterface

// File: rtl/seg_decoder.sv
// Recovers 4-digit hex frames from a strobed 7-segment bus: each digit must be
// stable for STABLE_CYCLES samples before it is decoded into its slot.
module seg_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  seg_decoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [6:0]        seg_q, seg_p_q;
  logic [3:0]        an_q, an_p_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        captured_q, captured_d;
  logic [3:0][3:0]   slots_q, slots_d;
  logic [3:0]        inv_q, inv_d;
  logic [15:0]       value_q, value_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              onehot, changed, cap, complete, bad;
  logic [1:0]        idx;
  logic [3:0]        nib;

  // Returns {invalid, nibble}; unknown patterns decode to 0 with invalid set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h7E: decode = 5'h00;
      7'h30: decode = 5'h01;
      7'h6D: decode = 5'h02;
      7'h79: decode = 5'h03;
      7'h33: decode = 5'h04;
      7'h5B: decode = 5'h05;
      7'h5F: decode = 5'h06;
      7'h70: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h7B: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h1F: decode = 5'h0B;
      7'h4E: decode = 5'h0C;
      7'h3D: decode = 5'h0D;
      7'h4F: decode = 5'h0E;
      7'h47: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    onehot  = (an_q != 4'b0000) && ((an_q & (an_q - 4'd1)) == 4'b0000);
    changed = ({seg_q, an_q} != {seg_p_q, an_p_q});
    case (an_q)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    {bad, nib} = decode(seg_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (onehot) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (changed) begin
          state_d = onehot ? SETTLE : IDLE;
          cnt_d   = onehot ? 8'd1 : 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(STABLE_CYCLES)) begin
            cap     = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (changed) begin
          state_d = onehot ? SETTLE : IDLE;
          cnt_d   = onehot ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Completion clears the frame first so a same-cycle capture starts the next one.
  always_comb begin
    complete   = &captured_q;
    captured_d = complete ? 4'b0000 : captured_q;
    inv_d      = complete ? 4'b0000 : inv_q;
    slots_d    = slots_q;
    if (cap) begin
      slots_d[idx]    = nib;
      inv_d[idx]      = bad;
      captured_d[idx] = 1'b1;
    end
    valid_d = complete;
    value_d = complete ? slots_q : value_q;
    err_d   = complete ? |inv_q : err_q;
    busy_d  = |captured_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      seg_q      <= '0;
      an_q       <= '0;
      seg_p_q    <= '0;
      an_p_q     <= '0;
      cnt_q      <= '0;
      captured_q <= '0;
      slots_q    <= '0;
      inv_q      <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= bus.seg;
      an_q       <= bus.an;
      seg_p_q    <= seg_q;
      an_p_q     <= an_q;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      slots_q    <= slots_d;
      inv_q      <= inv_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_seg_decoder.sv
// Directed frames for seg_decoder; expected frames queued at issue, checked by a monitor.
module tb_seg_decoder;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  logic [16:0] exp_q[$];

  seg_decoder_if ifc();
  seg_decoder #(.STABLE_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst === 1'b0 && ifc.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_valid: got value=%h err=%b expected no pulse", ifc.value, ifc.err);
      end else begin
        e = exp_q.pop_front();
        chk("frame_value", 32'(ifc.value), 32'(e[15:0]));
        chk("frame_err", 32'(ifc.err), 32'(e[16]));
      end
    end
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    ifc.an  = a;
    ifc.seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_value", 32'(ifc.value), 32'h0);
    chk("rst_valid", 32'(ifc.valid), 32'h0);
    chk("rst_err", 32'(ifc.err), 32'h0);
    chk("rst_busy", 32'(ifc.busy), 32'h0);
    rst = 1'b0;
  endtask

  // Four 8-cycle digit holds; the last digit's valid latency is measured.
  task automatic frame4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input logic [16:0] exp);
    int lat;
    exp_q.push_back(exp);
    hold(4'b0001, s0, 8);
    hold(4'b0010, s1, 8);
    hold(4'b0100, s2, 8);
    chk("busy_mid_frame", 32'(ifc.busy), 32'h1);
    ifc.an  = 4'b1000;
    ifc.seg = s3;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ifc.valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("valid_latency", 32'(lat), 32'd6);
    if (lat < 8) repeat (8 - lat) @(negedge clk);
    chk("busy_after_frame", 32'(ifc.busy), 32'h0);
  endtask

  initial begin
    rst     = 1'b1;
    ifc.an  = 4'b0000;
    ifc.seg = 7'h00;
    repeat (2) @(negedge clk);
    do_reset();

    frame4(7'h7E, 7'h30, 7'h6D, 7'h79, {1'b0, 16'h3210});
    frame4(7'h77, 7'h1F, 7'h4E, 7'h3D, {1'b0, 16'hDCBA});
    frame4(7'h4F, 7'h47, 7'h5F, 7'h7F, {1'b0, 16'h86FE});
    frame4(7'h33, 7'h70, 7'h7B, 7'h5B, {1'b0, 16'h5974});
    chk("value_holds", 32'(ifc.value), 32'h5974);
    frame4(7'h7E, 7'h30, 7'h00, 7'h79, {1'b1, 16'h3010});
    chk("err_holds", 32'(ifc.err), 32'h1);

    // Short hold on digit 0 must not capture.
    do_reset();
    hold(4'b0001, 7'h5B, 3);
    hold(4'b0010, 7'h30, 3);
    chk("short_hold_busy", 32'(ifc.busy), 32'h0);
    hold(4'b0010, 7'h30, 5);
    chk("full_hold_busy", 32'(ifc.busy), 32'h1);
    frame4(7'h5B, 7'h30, 7'h6D, 7'h79, {1'b0, 16'h3215});

    // Illegal strobes never capture.
    do_reset();
    hold(4'b0011, 7'h7E, 10);
    hold(4'b0000, 7'h7E, 10);
    chk("illegal_an_busy", 32'(ifc.busy), 32'h0);

    // Partial frame discarded by reset.
    hold(4'b0001, 7'h7E, 8);
    hold(4'b0010, 7'h30, 8);
    hold(4'b0100, 7'h6D, 8);
    chk("partial_busy", 32'(ifc.busy), 32'h1);
    do_reset();
    hold(4'b0000, 7'h00, 3);
    frame4(7'h7E, 7'h30, 7'h6D, 7'h79, {1'b0, 16'h3210});

    // Recapture of slot 0 overwrites it.
    hold(4'b0001, 7'h7E, 8);
    frame4(7'h7F, 7'h30, 7'h6D, 7'h79, {1'b0, 16'h3218});
    hold(4'b0000, 7'h00, 5);

    do_reset();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seg_decoder.md
SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive identical-sample cycles needed before a digit is accepted; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg  input  7  segment bus, seg[6:0]={a,b,c,d,e,f,g}, 1=segment lit.
REQ-005 an  input  4  digit enables, active-high; an[i] selects digit i; a legal strobe has exactly one bit set.
REQ-006 value  output  16  last complete frame, {digit3,digit2,digit1,digit0}, one nibble per digit.
REQ-007 valid  output  1  one-cycle pulse; value and err are updated in the same cycle.
REQ-008 err  output  1  high with valid when any digit in that frame held an unrecognised pattern.
REQ-009 busy  output  1  high while at least one digit slot of the current frame is captured.

Function
REQ-010 seg and an SHALL be registered once before any other use; all comparisons use the registered copies.
REQ-011 Decode table, seg hex to nibble: 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9, 77=A, 1F=b, 4E=C, 3D=d, 4F=E, 47=F.
REQ-012 Any other seg pattern SHALL decode to nibble 0 and set that slot's invalid flag.
REQ-013 The FSM SHALL have three states: IDLE, SETTLE and HOLD.
REQ-014 IDLE: entered when registered an is not one-hot (zero or multiple bits); stability counter held at 0; no capture.
REQ-015 IDLE->SETTLE: registered an becomes one-hot; counter set to 1.
REQ-016 SETTLE: the counter increments each cycle that {seg,an} equals the previous cycle's sample.
REQ-017 Any change in {seg,an} while in SETTLE restarts the counter at 1, or moves to IDLE if an is no longer one-hot.
REQ-018 SETTLE->HOLD: when the counter reaches STABLE_CYCLES, decode seg into slot i (i = index of the an bit), write that slot's invalid flag, and set captured[i].
REQ-019 HOLD: no further capture. Any change in {seg,an} moves to SETTLE (counter=1) if an is one-hot, or to IDLE if it is not.
REQ-020 A slot that is captured again before the frame completes SHALL be overwritten with the newer nibble and invalid flag.
REQ-021 Frame completion: on the cycle after captured becomes 4'b1111, valid=1, value is loaded from the four slots, and err is loaded from the OR of the four invalid flags.
REQ-022 In the frame-completion cycle, captured and the invalid flags SHALL be cleared.
REQ-023 A capture that lands in the frame-completion cycle SHALL count toward the next frame.
REQ-024 Latency: from the first cycle of a stable sample at the input pins, a capture occurs after 1 + STABLE_CYCLES clock edges. valid rises 1 cycle after the fourth capture.
REQ-025 value and err SHALL hold between valid pulses. valid SHALL never be high in two consecutive cycles.
REQ-026 busy = OR of captured bits, registered.

Reset
REQ-027 rst high at a clock edge SHALL set the following: state=IDLE, counter=0, captured=0, slots=0, invalid flags=0, value=16'h0000, valid=0, err=0, busy=0, and the input sample registers to 0.
REQ-028 Reset asserted mid-frame SHALL discard any partial frame. No valid pulse is issued for that frame.
REQ-029 After reset deasserts, operation resumes in IDLE on the next cycle.

Verification
REQ-030 STABLE_CYCLES=4. Drive an=0001/seg=7E, 0010/30, 0100/6D, 1000/79, each for 8 cycles -> one valid pulse, value=16'h3210, err=0.
REQ-031 Hold digit 0 for only 3 cycles (an=0001, seg=5B), then switch to an=0010 -> no capture of slot 0, busy stays 0 until a later full-length hold.
REQ-032 Drive the same four strobes as REQ-030, but with digit 2 seg=00 -> valid pulse with value=16'h3010 and err=1.
REQ-033 Drive an=0011 for 10 cycles, then an=0000 for 10 cycles -> no capture, busy=0, valid stays 0.
REQ-034 Capture digits 0..2, assert rst for 1 cycle, then run the full REQ-030 sequence -> exactly one valid pulse with value=16'h3210.
REQ-035 Capture digit 0 with seg=7E, then recapture it with seg=7F before digits 1..3 -> the frame reports value[3:0]=8.
